// File: rtl/alu_result_serializer_if.sv
// Operand-in and result-out handshake bundle for alu_result_serializer.
// slave is the serializer's view; master is the source/consumer side.
interface alu_result_serializer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_op;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_div0;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_data, out_last, out_div0
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_data, out_last, out_div0
    );
endinterface

// File: rtl/alu_result_serializer.sv
// Registers an operand pair onto the external 4-bit ALU, snapshots its nine
// results, then streams them out one opcode-tagged beat per handshake.
module alu_result_serializer #(
    parameter logic [7:0] DIV0_VALUE = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_result_serializer_if.slave     bus,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    input  logic [7:0]                 alu_sum,
    input  logic [7:0]                 alu_diff,
    input  logic [7:0]                 alu_product,
    input  logic [7:0]                 alu_quotient,
    input  logic [3:0]                 alu_and,
    input  logic [3:0]                 alu_or,
    input  logic [3:0]                 alu_xor,
    input  logic [3:0]                 alu_not_a,
    input  logic [3:0]                 alu_not_b,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic [3:0] idx_nxt;
    logic [7:0] snap [9];
    logic       div0;
    logic       load_ops;
    logic       capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (load_ops) begin
            alu_a <= bus.in_a;
            alu_b <= bus.in_b;
        end
    end

    // The divide-by-zero substitution is folded in at capture time so the
    // emit path is a plain table lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 9; i++) begin
                snap[i] <= '0;
            end
            div0 <= 1'b0;
        end else if (capture) begin
            snap[0] <= alu_sum;
            snap[1] <= alu_diff;
            snap[2] <= alu_product;
            snap[3] <= (alu_b == '0) ? DIV0_VALUE : alu_quotient;
            snap[4] <= {4'h0, alu_and};
            snap[5] <= {4'h0, alu_or};
            snap[6] <= {4'h0, alu_xor};
            snap[7] <= {4'h0, alu_not_a};
            snap[8] <= {4'h0, alu_not_b};
            div0    <= (alu_b == '0);
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        load_ops     = 1'b0;
        capture      = 1'b0;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_op   = '0;
        bus.out_data = '0;
        bus.out_last = 1'b0;
        bus.out_div0 = 1'b0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_ops  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                capture   = 1'b1;
                idx_nxt   = '0;
                state_nxt = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_op    = idx;
                bus.out_data  = (idx <= 4'd8) ? snap[idx] : '0;
                bus.out_last  = (idx == 4'd8);
                bus.out_div0  = (idx == 4'd3) && div0;
                if (bus.out_ready) begin
                    if (idx == 4'd8) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: behavioural ALU, queue-based beat model,
// per-cycle compare process and directed/random transactions.
module tb_alu_result_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_result_serializer_if bus();

    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_sum, alu_diff, alu_product, alu_quotient;
    logic [3:0] alu_and, alu_or, alu_xor, alu_not_a, alu_not_b;
    logic       busy;

    // Quotient is deliberately garbage on B==0: the serializer must ignore it.
    assign alu_sum      = {4'h0, alu_a} + {4'h0, alu_b};
    assign alu_diff     = {4'h0, alu_a} - {4'h0, alu_b};
    assign alu_product  = {4'h0, alu_a} * {4'h0, alu_b};
    assign alu_quotient = (alu_b == 4'h0) ? 8'hAA : ({4'h0, alu_a} / {4'h0, alu_b});
    assign alu_and      = alu_a & alu_b;
    assign alu_or       = alu_a | alu_b;
    assign alu_xor      = alu_a ^ alu_b;
    assign alu_not_a    = ~alu_a;
    assign alu_not_b    = ~alu_b;

    alu_result_serializer #(.DIV0_VALUE(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sum      (alu_sum),
        .alu_diff     (alu_diff),
        .alu_product  (alu_product),
        .alu_quotient (alu_quotient),
        .alu_and      (alu_and),
        .alu_or       (alu_or),
        .alu_xor      (alu_xor),
        .alu_not_a    (alu_not_a),
        .alu_not_b    (alu_not_b),
        .busy         (busy)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
        logic       last;
        logic       div0;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      obs[$];
    beat_t      ent;
    beat_t      popped;
    logic       model_busy = 1'b0;
    logic       model_load = 1'b0;
    logic [3:0] model_a = 4'h0;
    logic [3:0] model_b = 4'h0;
    logic       rand_ready = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic logic [7:0] ref_result(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            3:       r = (b == 0) ? 255 : a / b;
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a ^ b;
            7:       r = 15 - a;
            8:       r = 15 - b;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired or entry missing", name);
    endtask

    // Transaction-level model: an accept enqueues all nine beats, each ready
    // cycle after the single load cycle retires one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_busy = 1'b0;
            model_load = 1'b0;
            model_a    = 4'h0;
            model_b    = 4'h0;
        end else if (model_load) begin
            model_load = 1'b0;
        end else if (model_busy) begin
            if (bus.out_ready && exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                if (popped.last) model_busy = 1'b0;
            end
        end else if (bus.in_valid) begin
            model_a = bus.in_a;
            model_b = bus.in_b;
            for (int op = 0; op < 9; op++) begin
                ent.op   = 4'(op);
                ent.data = ref_result(op, int'(bus.in_a), int'(bus.in_b));
                ent.last = (op == 8);
                ent.div0 = (op == 3) && (bus.in_b == 4'h0);
                exp_q.push_back(ent);
            end
            model_busy = 1'b1;
            model_load = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(model_busy));
            chk("in_ready", 32'(bus.in_ready), 32'(!model_busy));
            chk("out_valid", 32'(bus.out_valid), 32'(model_busy && !model_load));
            chk("alu_a", 32'(alu_a), 32'(model_a));
            chk("alu_b", 32'(alu_b), 32'(model_b));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    chk("out_op", 32'(bus.out_op), 32'(exp_q[0].op));
                    chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
                    chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                    chk("out_div0", 32'(bus.out_div0), 32'(exp_q[0].div0));
                    chk("out_data_known", 32'($isunknown(bus.out_data)), 32'd0);
                end
                if (bus.out_ready)
                    obs.push_back({bus.out_op, bus.out_data, bus.out_last, bus.out_div0});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus.out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        logic r;
        int   c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            r = !model_busy;
            @(posedge clk);
            if (r) break;
        end
        if (c == 100) fail_now("send_accept");
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!model_busy && exp_q.size() == 0) break;
        end
        if (c == 400) fail_now("wait_idle");
    endtask

    task automatic check_beat(input string name, input int i, input logic [7:0] data,
                              input logic div0);
        if (i >= obs.size()) begin
            fail_now(name);
        end else begin
            chk({name, "_op"}, 32'(obs[i].op), 32'(i % 9));
            chk({name, "_data"}, 32'(obs[i].data), 32'(data));
            chk({name, "_div0"}, 32'(obs[i].div0), 32'(div0));
        end
    endtask

    task automatic set_ready_high();
        rand_ready = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
    endtask

    logic [7:0] t1 [9];
    int         first_valid, first_ready, c;

    initial begin
        t1 = '{8'h1C, 8'h02, 8'hC3, 8'h01, 8'h0D, 8'h0F, 8'h02, 8'h00, 8'h02};
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_div0", 32'(bus.out_div0), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        #10 rst_n = 1'b1;

        // F/D with ready high: latency, literal beat table, last flag.
        set_ready_high();
        obs.delete();
        send(4'hF, 4'hD);
        first_valid = 0;
        first_ready = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.out_valid && first_valid == 0) first_valid = k;
            if (bus.in_ready && first_ready == 0) first_ready = k;
        end
        chk("first_beat_latency", 32'(first_valid), 32'd2);
        chk("in_ready_return", 32'(first_ready), 32'd11);
        wait_idle();
        chk("fd_beat_count", 32'(obs.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check_beat("fd", i, t1[i], 1'b0);
            if (i < obs.size()) chk("fd_last", 32'(obs[i].last), 32'(i == 8));
        end

        obs.delete();
        send(4'h3, 4'h5);
        wait_idle();
        check_beat("a3b5_diff", 1, 8'hFE, 1'b0);
        check_beat("a3b5_prod", 2, 8'h0F, 1'b0);
        check_beat("a3b5_quot", 3, 8'h00, 1'b0);
        check_beat("a3b5_xor", 6, 8'h06, 1'b0);
        check_beat("a3b5_notb", 8, 8'h0A, 1'b0);

        obs.delete();
        send(4'h9, 4'h0);
        wait_idle();
        check_beat("div0_sum", 0, 8'h09, 1'b0);
        check_beat("div0_prod", 2, 8'h00, 1'b0);
        check_beat("div0_quot", 3, 8'hFF, 1'b1);
        check_beat("div0_and", 4, 8'h00, 1'b0);
        check_beat("div0_notb", 8, 8'h0F, 1'b0);

        // Stall on op 2 for three cycles, then random ready.
        obs.delete();
        send(4'hF, 4'hD);
        for (c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_op == 4'd1) break;
        end
        if (c == 50) fail_now("stall_sync");
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_op", 32'(bus.out_op), 32'd2);
            chk("stall_data", 32'(bus.out_data), 32'hC3);
            @(posedge clk);
        end
        rand_ready = 1'b1;
        wait_idle();
        chk("stall_beat_count", 32'(obs.size()), 32'd9);
        for (int i = 0; i < 9; i++) check_beat("stall_seq", i, t1[i], 1'b0);

        // Request held during an active transaction.
        set_ready_high();
        obs.delete();
        send(4'h3, 4'h5);
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        #1;
        bus.in_valid = 1'b1;
        bus.in_a     = 4'h1;
        bus.in_b     = 4'h1;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        chk("held_req_wait", 32'(c), 32'd9);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_idle();
        chk("held_beat_count", 32'(obs.size()), 32'd18);
        check_beat("held_first_sum", 0, 8'h08, 1'b0);
        check_beat("held_next_sum", 9, 8'h02, 1'b0);

        // Reset while op 4 is presented.
        send(4'hF, 4'hD);
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_op == 4'd4) break;
        end
        if (c == 20) fail_now("reset_sync");
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        obs.delete();
        send(4'h2, 4'h1);
        wait_idle();
        chk("postrst_beat_count", 32'(obs.size()), 32'd9);
        check_beat("postrst_sum", 0, 8'h03, 1'b0);

        // Random operands with random back-pressure.
        obs.delete();
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            send(4'($urandom_range(0, 15)), (t % 5 == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
            wait_idle();
        end
        chk("random_beat_count", 32'(obs.size()), 32'd360);
        set_ready_high();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
Sequential front/back end for the 4-bit combinational ALU.
- Accepts one operand pair per transaction over a valid/ready handshake and drives the pair onto the ALU operand inputs.
- Snapshots all nine ALU results one cycle later.
- Streams the results out one per beat, tagged with an opcode, over a valid/ready output handshake.
- Sits between the operand source (register file or test stimulus) and the result consumer (display/log or writeback).

Parameters:
DIV0_VALUE, 8'hFF, quotient value emitted when the captured B operand is zero; the ALU's own quotient output is ignored in that case.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_a  input  4  operand A
in_b  input  4  operand B
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_sum  input  8  ALU A+B
alu_diff  input  8  ALU A-B, 8-bit two's complement
alu_product  input  8  ALU A*B
alu_quotient  input  8  ALU A/B
alu_and  input  4  ALU A&B
alu_or  input  4  ALU A|B
alu_xor  input  4  ALU A^B
alu_not_a  input  4  ALU ~A
alu_not_b  input  4  ALU ~B
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts beat
out_op  output  4  opcode of current beat
out_data  output  8  result of current beat
out_last  output  1  current beat is final (op 8)
out_div0  output  1  current beat is a quotient with B==0
busy  output  1  transaction in progress

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; alu_a=0, alu_b=0; out_valid=0, out_op=0, out_data=0, out_last=0, out_div0=0; busy=0; in_ready=1 (in_ready = state==IDLE); snapshot registers=0.
- FSM states: IDLE, LOAD, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: alu_a<=in_a, alu_b<=in_b, state->LOAD.
- LOAD (1 cycle, in_ready=0, out_valid=0):
  - ALU settles combinationally from alu_a/alu_b.
  - Capture all nine ALU inputs into snapshot registers; div0<=(alu_b==0); idx<=0; state->EMIT.
- EMIT:
  - out_valid=1, out_op=idx, out_data=snapshot[idx], out_last=(idx==8), out_div0=(idx==3)&&div0.
  - On out_valid&&out_ready: if idx==8, state->IDLE; else idx<=idx+1.
  - All outputs held stable while out_ready=0. No beat is skipped or repeated.
- Opcode order: 0 SUM, 1 DIFF, 2 PRODUCT, 3 QUOTIENT, 4 AND, 5 OR, 6 XOR, 7 NOT_A, 8 NOT_B. Codes 9-15 are never emitted.
- Width rules:
  - 4-bit results are zero-extended to 8 bits.
  - 8-bit results pass through unmodified; DIFF wraps mod 256.
  - QUOTIENT beat carries DIV0_VALUE when div0=1, otherwise alu_quotient.
- Latency and throughput:
  - First beat is valid 2 cycles after the accept edge.
  - With out_ready tied high, a transaction occupies 11 cycles.
  - in_ready reasserts in the cycle after the op-8 handshake.
- in_valid during LOAD/EMIT: ignored, with no side effects. The source must hold the request until in_ready is high.
- busy = (state != IDLE).
- alu_a/alu_b retain the last accepted operands after the transaction completes.
- Reset mid-transaction: immediate abort.
  - out_valid drops asynchronously and state returns to IDLE.
  - The partial stream is not resumed; the next transaction starts at op 0.

Test Plan:
- A=4'hF, B=4'hD, out_ready=1 -> beats (op,data): (0,1C) (1,02) (2,C3) (3,01) (4,0D) (5,0F) (6,02) (7,00) (8,02); out_last only on op 8; out_div0 never set; in_ready high 11 cycles after accept.
- A=3, B=5 -> DIFF=0xFE, PRODUCT=0x0F, QUOTIENT=0x00, XOR=0x06, NOT_B=0x0A; out_div0=0.
- A=9, B=0 -> SUM=0x09, PRODUCT=0x00, QUOTIENT beat=0xFF with out_div0=1 on that beat only; NOT_B=0x0F.
- A=F, B=D; out_ready low for 3 cycles while op 2 is presented, then random out_ready -> op 2/0xC3 held stable while stalled; exactly 9 beats in order; no X on out_data.
- in_valid held high with A=1, B=1 during EMIT of a prior transaction -> in_ready=0 and no effect until after the op-8 handshake; accepted the next cycle; SUM beat=0x02.
- rst_n pulsed low while op 4 is presented -> out_valid=0, busy=0, in_ready=1 immediately; the following transaction A=2, B=1 emits from op 0 with SUM=0x03.
